// File: rtl/keypad_scanner.sv
// Purpose: matrix keypad scanner with a row synchroniser, press/release debounce and multi-key rejection.
// Latency: press accepted DEBOUNCE-1 scan ticks after the first matching tick; events appear 1 clk after that tick.
// Backpressure: none; key_valid/key_release are single-cycle pulses and are never queued.
//
// Ports:
//   clk, rst_n   - system clock (rising edge), asynchronous active-low reset
//   row          - row sense lines, active-high, asynchronous to clk
//   col          - one-hot active-high column drive
//   key_code     - row_idx*COLS + col_idx of the last accepted key (kept after release)
//   key_valid    - one-cycle pulse on press acceptance
//   key_release  - one-cycle pulse on release acceptance
//   key_held     - level from press acceptance until release acceptance
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int CIDX_W = $clog2(COLS);
    localparam int RIDX_W = $clog2(ROWS);
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);

    localparam logic [ROWS-1:0]   ROW_ONE  = ROWS'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(COLS - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD,
        RELEASE
    } state_t;

    state_t            state_q;
    logic [ROWS-1:0]   sync1_q;
    logic [ROWS-1:0]   row_s;
    logic [DIV_W-1:0]  div_q;
    logic [CIDX_W-1:0] col_idx_q;
    logic [ROWS-1:0]   pat_q;
    logic [RIDX_W-1:0] pat_idx_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              tick;
    logic              row_zero;
    logic              row_single;
    logic [CIDX_W-1:0] col_idx_nxt;
    logic [COLS-1:0]   col_nxt;
    logic [CNT_W-1:0]  cnt_inc;

    // Index of the set bit of a one-hot row pattern.
    function automatic logic [RIDX_W-1:0] onehot_idx(input logic [ROWS-1:0] v);
        logic [RIDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) idx = RIDX_W'(i);
        end
        return idx;
    endfunction

    assign tick        = (div_q == DIV_LAST);
    assign row_zero    = (row_s == '0);
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign row_single  = !row_zero && ((row_s & (row_s - ROW_ONE)) == '0);
    assign col_idx_nxt = (col_idx_q == COL_LAST) ? '0 : col_idx_q + CIDX_W'(1);
    assign col_nxt     = COLS'(1) << col_idx_nxt;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            row_s       <= '0;
            div_q       <= '0;
            state_q     <= SCAN;
            col_idx_q   <= '0;
            col         <= COLS'(1);
            pat_q       <= '0;
            pat_idx_q   <= '0;
            cnt_q       <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            sync1_q     <= row;
            row_s       <= sync1_q;
            div_q       <= tick ? '0 : div_q + DIV_W'(1);
            key_valid   <= 1'b0;
            key_release <= 1'b0;

            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (row_single) begin
                            // Stay on this column while the key is confirmed.
                            pat_q     <= row_s;
                            pat_idx_q <= onehot_idx(row_s);
                            cnt_q     <= CNT_W'(1);
                            state_q   <= CONFIRM;
                        end else begin
                            col_idx_q <= col_idx_nxt;
                            col       <= col_nxt;
                        end
                    end
                    CONFIRM: begin
                        if (row_s == pat_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                key_code  <= CODE_W'(int'(pat_idx_q) * COLS + int'(col_idx_q));
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state_q   <= HELD;
                            end
                        end else begin
                            state_q   <= SCAN;
                            col_idx_q <= col_idx_nxt;
                            col       <= col_nxt;
                        end
                    end
                    HELD: begin
                        // Extra keys on this column are ignored while a key is held.
                        if (row_zero) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (row_zero) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                key_release <= 1'b1;
                                key_held    <= 1'b0;
                                state_q     <= SCAN;
                                col_idx_q   <= col_idx_nxt;
                                col         <= col_nxt;
                            end
                        end else begin
                            state_q <= HELD;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the calculator input unit. It replaces the fixed 4x4, 500 Hz scan with configurable matrix size, scan rate and debounce depth. It adds a 2-flop row synchroniser, per-key debounce on both press and release, and rejection of multi-key presses. Output is a raw key code plus single-cycle press and release events, which feed the downstream key decoder and the input FSM.

## Interface
- ROWS, 4, number of row sense lines (>=2)
- COLS, 4, number of column drive lines (>=2)
- SCAN_DIV, 100000, clk cycles per scan tick (>=2); 100000 gives 500 Hz from 50 MHz
- DEBOUNCE, 4, consecutive identical tick samples needed to accept a press or a release (>=2)
- CODE_W, $clog2(ROWS*COLS), width of key_code
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- row  in  ROWS  row sense, active-high (a pressed key connects the driven column to its row); asynchronous to clk
- col  out  COLS  column drive, one-hot active-high
- key_code  out  CODE_W  row_idx*COLS + col_idx of the last accepted key
- key_valid  out  1  single-cycle pulse when a press is accepted
- key_release  out  1  single-cycle pulse when the release of the held key is accepted
- key_held  out  1  level, high from press acceptance until release acceptance

## Operation
- Reset values: col = 1 (column 0), key_code = 0, key_valid = 0, key_release = 0, key_held = 0, state = SCAN, divider = 0, debounce count = 0, synchroniser = 0.
- Synchroniser: row passes through two flops to form row_s. All decisions use row_s only.
- Tick: the divider counts 0..SCAN_DIV-1 and wraps to 0. tick is high for one clk cycle when divider == SCAN_DIV-1. State advances only on tick cycles.
- "Single" means exactly one bit of row_s is set. "Zero" means row_s == 0.
- SCAN: col is the one-hot of col_idx. On tick:
  - if row_s is single, latch the pattern and its row_idx, set cnt = 1, go to CONFIRM, and keep col_idx.
  - otherwise (zero or multiple bits), advance col_idx, wrapping COLS-1 -> 0.
- CONFIRM: col is held. On tick:
  - if row_s equals the latched pattern, increment cnt. When cnt reaches DEBOUNCE, load key_code, pulse key_valid, set key_held and go to HELD.
  - on any mismatch, go to SCAN and advance col_idx. No event is produced.
- HELD: col is held and key_held = 1. On tick:
  - if row_s is zero, set cnt = 1 and go to RELEASE.
  - any nonzero row_s, including extra keys, keeps the state at HELD.
- RELEASE: on tick:
  - if row_s is zero, increment cnt. When cnt reaches DEBOUNCE, pulse key_release, clear key_held, go to SCAN and advance col_idx.
  - if row_s is nonzero, return to HELD. No event is produced.
- key_code holds its value after release until the next accepted press.
- Only one key is reported at a time. A second key pressed while in HELD is ignored and is not queued.
- Asserting rst_n low mid-operation, in any state, forces reset values immediately. No release event is produced for a key held across reset.

## Timing
- Every output is registered. key_valid and key_release are high for exactly the clk cycle after the deciding tick cycle.
- col changes in the clk cycle after a tick, so each column is driven for SCAN_DIV cycles before it is sampled.
- Synchroniser latency is 2 clk. A row change must be stable for at least 2 clk before a tick to be seen on that tick.
- Press latency for a stable key, in ticks from the first tick on which its column is driven and row_s is set: DEBOUNCE-1 ticks to acceptance, +1 clk to the key_valid pulse.
- Worst-case detection delay from key closure: (COLS + DEBOUNCE) * SCAN_DIV + 3 clk.
- Release latency: DEBOUNCE-1 ticks after the first zero sample, +1 clk.
- key_valid and key_release never assert in the same cycle. key_held rises in the same cycle as key_valid and falls in the same cycle as key_release.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3.
- Reset/idle: hold rst_n low, release it, and apply row=0 for 64 cycles -> col cycles 0001,0010,0100,1000,0001 changing every 4 clk; no events; key_held=0.
- Clean press/release of row 2, col 1: assert row[2] only while col[1] is driven, held for 10 ticks, then release -> one key_valid with key_code=9 exactly 2 ticks+1 clk after the first matching tick; key_held high throughout; one key_release 2 ticks+1 clk after the first zero sample; scanning resumes at col 2.
- Bounce rejection: row[0] toggles each tick for 6 ticks on col 3 -> no key_valid. Then stable for 3 ticks -> key_valid with key_code=3.
- Multi-key rejection: row=0101 while col 0 is driven -> col keeps advancing and no key_valid. While HELD on code 9, add row[3] -> no new event and key_code stays 9.
- Release bounce: in HELD, row goes 0, nonzero, 0, 0, 0 on successive ticks -> key_release only after the final three consecutive zeros, and exactly one pulse.
- Async reset mid-CONFIRM and mid-HELD: pull rst_n low between clock edges -> all outputs take their reset values immediately, col=0001, and no key_release pulse.
